// File: rtl/fsm6_pkg.sv
// Shared encoding and transition function for the six-state A..F sequence detector.
package fsm6_pkg;

    typedef enum logic [2:0] {
        S_A = 3'b000,
        S_B = 3'b001,
        S_C = 3'b010,
        S_D = 3'b011,
        S_E = 3'b100,
        S_F = 3'b101
    } state_t;

    localparam int NUM_LEGAL = 6;

    // Codes 110/111 are not enum members; they fall through to A.
    function automatic state_t fsm6_next(state_t s, logic w);
        case (s)
            S_A:     return w ? S_A : S_B;
            S_B:     return w ? S_D : S_C;
            S_C:     return w ? S_D : S_E;
            S_D:     return w ? S_A : S_F;
            S_E:     return w ? S_D : S_E;
            S_F:     return w ? S_D : S_C;
            default: return S_A;
        endcase
    endfunction

endpackage

// File: rtl/fsm6_chan.sv
// One detector channel: state register, {E,F}-entry saturating counter, illegal-state flag.
// FSM6_ILLEGAL_TRAP_EN enables the sticky err flag and forced recovery from illegal codes.
module fsm6_chan
    import fsm6_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             w,
    input  logic             ld_en,
    input  logic [2:0]       ld_state,
    input  logic             cnt_clr,
    output logic [2:0]       state,
    output logic             z,
    output logic             y1_next,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    state_t           state_q;
    state_t           state_d;
    state_t           step_nxt;
    logic             z_d;
    logic [CNT_W-1:0] cnt_q;

`ifdef FSM6_ILLEGAL_TRAP_EN
    logic illegal;
    logic err_q;
    assign illegal = (state_q >= 3'(NUM_LEGAL));
`endif

    always_comb begin
        step_nxt = fsm6_next(state_q, w);
        state_d  = state_q;
        if (ld_en) begin
            state_d = state_t'(ld_state);
`ifdef FSM6_ILLEGAL_TRAP_EN
        end else if (illegal) begin
            state_d = S_A;
`endif
        end else if (in_valid) begin
            state_d = step_nxt;
        end
        z_d = (state_d == S_E) || (state_d == S_F);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Count only 0->1 edges of z, so E<->F moves are not entries.
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (z_d && !z && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef FSM6_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign state   = state_q;
    assign z       = (state_q == S_E) || (state_q == S_F);
    assign y1_next = step_nxt[1];
    assign cnt     = cnt_q;

endmodule

// File: rtl/fsm6_chan_array.sv
// NCH independent A..F detector channels sharing one step qualifier.
// Optional illegal-state trap is selected by FSM6_ILLEGAL_TRAP_EN.
module fsm6_chan_array
    import fsm6_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [NCH-1:0]       w,
    input  logic [NCH-1:0]       ld_en,
    input  logic [3*NCH-1:0]     ld_state,
    input  logic                 cnt_clr,
    output logic [3*NCH-1:0]     state,
    output logic [NCH-1:0]       z,
    output logic [NCH-1:0]       y1_next,
    output logic [CNT_W*NCH-1:0] cnt,
    output logic [NCH-1:0]       err
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        fsm6_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .in_valid(in_valid),
            .w       (w[i]),
            .ld_en   (ld_en[i]),
            .ld_state(ld_state[3*i +: 3]),
            .cnt_clr (cnt_clr),
            .state   (state[3*i +: 3]),
            .z       (z[i]),
            .y1_next (y1_next[i]),
            .cnt     (cnt[CNT_W*i +: CNT_W]),
            .err     (err[i])
        );
    end

endmodule

// File: doc/fsm6_chan_array.md
Name: fsm6_chan_array

Overview:
- Parametrised, registered successor to the six-state A–F sequence-detector next-state logic.
- Runs NCH independent copies of the A..F Moore FSM, each stepped by a shared input-valid qualifier.
- Provides per-channel registered state, Moore output z, combinational next-state bit 1 (Y1-compatible), state injection, and saturating entry counters.
- Sits in the detector datapath and feeds status and monitor logic.

Parameters:
- NCH, 4, number of independent FSM channels (1..32).
- CNT_W, 8, width of each per-channel saturating E/F-entry counter (2..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  step qualifier; all channels advance only when it is high.
- w  input  NCH  per-channel FSM input bit.
- ld_en  input  NCH  per-channel state-load strobe.
- ld_state  input  3*NCH  per-channel load value; channel i uses bits [3i+2:3i].
- cnt_clr  input  1  synchronous clear of all counters.
- state  output  3*NCH  registered per-channel state.
- z  output  NCH  Moore output: 1 when the channel is in E or F.
- y1_next  output  NCH  combinational bit 1 of the next state, from current state and w.
- cnt  output  CNT_W*NCH  per-channel count of entries into {E,F}.
- err  output  NCH  sticky illegal-state flag (see Optional Feature).

Behaviour:
- State encoding (shared package): A=000, B=001, C=010, D=011, E=100, F=101; 110 and 111 are illegal.
- Transitions, written as w=0 / w=1:
  - A: B / A
  - B: C / D
  - C: E / D
  - D: F / A
  - E: E / D
  - F: C / D
  - Illegal state: A / A
- y1_next[i] = bit 1 of next(state_i, w[i]), purely combinational.
  - It does not depend on in_valid or ld_en.
  - For legal states it must match the 12-entry table exactly; illegal states give 0.
- Reset (synchronous, active-high, highest priority):
  - state = A (000) on all channels.
  - z = 0, cnt = 0, err = 0.
  - Asserting reset mid-sequence aborts that sequence; the next edge after reset deasserts begins from A.
- Per-channel update at the rising edge, in priority order: reset > ld_en[i] > in_valid > hold.
  - ld_en[i]: state_i <= ld_state_i, loaded verbatim, including illegal codes.
  - in_valid, no load: state_i <= next(state_i, w[i]).
  - Neither: state holds.
- Latency: a step presented in cycle t is visible on state and z in cycle t+1.
- z[i] = (state_i == E) | (state_i == F). It is decoded from the registered state and therefore glitch-free.
- Counter cnt_i:
  - Increments by 1 on any edge where z_i goes 0 to 1, whether caused by a step or by a load.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority over a same-cycle increment: the result is 0.
  - E to F and F to E moves do not count; F to C to E counts again.
- Boundary: in_valid stays low indefinitely, so state holds and nothing counts. ld_en and in_valid in the same cycle: the load wins and that step is discarded for the channel.

Optional Feature:
- Macro FSM6_ILLEGAL_TRAP_EN.
- Defined:
  - A registered illegal state (110 or 111) sets err[i], which is sticky until reset.
  - On the next edge the channel is forced to A regardless of in_valid. A same-cycle load still wins.
- Undefined:
  - err is tied to 0.
  - An illegal state recovers to A only on a valid step or a load.

Decomposition:
- Package fsm6_pkg holds:
  - typedef enum logic [2:0] state_t {S_A..S_F};
  - the function fsm6_next(state_t, logic w);
  - the constant NUM_LEGAL = 6.
- The natural sub-module is fsm6_chan: one channel holding the state register, counter and err flag. The top level instantiates it NCH times in a generate loop.

Test Plan:
- Reset, then in_valid=1 with w0=0,0,0 -> state0 steps B, C, E; z0=1 at cycle 3; cnt0=1.
- From E, apply w0=1 then 0 -> state0 = D then F; z0 goes 0 then 1; cnt0=2. Hold in_valid=0 for 5 cycles -> state0 stays F, cnt0 stays 2.
- Sweep all 12 {state,w} pairs via ld_en plus a comb check -> y1_next matches 0,0,1,1,0,1,0,0,0,1,1,1.
- Same cycle: ld_en1=1 with ld_state1=100, in_valid=1 and w1=1 -> state1=E (load wins); cnt1 increments. Same cycle: cnt_clr plus an increment -> cnt=0.
- CNT_W=2: force 4 E-entries -> cnt saturates at 3.
- With FSM6_ILLEGAL_TRAP_EN: load 111 -> err=1 and state=A on the next edge; err persists until reset.
- Reset asserted mid-sequence in state D -> all states A, cnt=0, err=0 on that edge.
